// File: rtl/operand_b_stage.sv
// ALU operand-B select stage: N-source select with rs2 forwarding, registered
// output with a one-entry skid buffer, flush, and a sticky illegal-select flag.
module operand_b_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 6,
  parameter int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        alu_srcB,
  input  logic [NUM_SRC*XLEN-1:0] src_flat,
  input  logic                    fwd_mem_valid,
  input  logic [XLEN-1:0]         fwd_mem_data,
  input  logic                    fwd_wb_valid,
  input  logic [XLEN-1:0]         fwd_wb_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         srcB,
  output logic                    sel_err
);

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_data_q,  out_data_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_data_q,  skid_data_d;
  logic            sel_err_q,   sel_err_d;

  logic [XLEN-1:0] sel_data;
  logic            sel_ill;
  logic            accept;

  // rs2 (index 0) is the only source that sees forwarding; MEM beats WB.
  always_comb begin
    sel_data = '0;
    sel_ill  = 1'b1;
    if (alu_srcB == '0) begin
      sel_ill = 1'b0;
      if (fwd_mem_valid)     sel_data = fwd_mem_data;
      else if (fwd_wb_valid) sel_data = fwd_wb_data;
      else                   sel_data = src_flat[0 +: XLEN];
    end
    for (int k = 1; k < NUM_SRC; k++) begin
      if (alu_srcB == SEL_W'(k)) begin
        sel_ill  = 1'b0;
        sel_data = src_flat[k*XLEN +: XLEN];
      end
    end
  end

  // Ready depends only on registered state, never on out_ready.
  assign in_ready = RST_N && !skid_valid_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    sel_err_d    = sel_err_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (accept && sel_ill) sel_err_d = 1'b1;
      if (!out_valid_q || out_ready) begin
        if (skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_data_d   = skid_data_q;
          skid_valid_d = accept;
          if (accept) skid_data_d = sel_data;
        end else if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = sel_data;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_data_d  = sel_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      sel_err_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign srcB      = out_data_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_operand_b_stage.sv
// Scoreboard bench for operand_b_stage: expected operands are queued at accept
// and compared when execute consumes them.
module tb_operand_b_stage;
  localparam int XLEN = 32;
  localparam int NSRC = 6;
  localparam int SELW = 3;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             in_valid;
  logic             in_ready;
  logic [SELW-1:0]  alu_srcB;
  logic [NSRC*XLEN-1:0] src_flat;
  logic             fwd_mem_valid, fwd_wb_valid;
  logic [XLEN-1:0]  fwd_mem_data, fwd_wb_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  srcB;
  logic             sel_err;

  logic [XLEN-1:0]  src [NSRC];
  logic [XLEN-1:0]  sb [$];
  int n_checks = 0;
  int n_err    = 0;
  logic             hold_pend = 1'b0;
  logic [XLEN-1:0]  hold_val  = '0;

  always #5 CLK = ~CLK;

  always_comb begin
    for (int k = 0; k < NSRC; k++) src_flat[k*XLEN +: XLEN] = src[k];
  end

  operand_b_stage #(.XLEN(XLEN), .NUM_SRC(NSRC)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .alu_srcB(alu_srcB), .src_flat(src_flat),
    .fwd_mem_valid(fwd_mem_valid), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_valid(fwd_wb_valid), .fwd_wb_data(fwd_wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .srcB(srcB), .sel_err(sel_err)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model(input int sel);
    if (sel == 0) begin
      if (fwd_mem_valid) return fwd_mem_data;
      if (fwd_wb_valid)  return fwd_wb_data;
      return src[0];
    end
    if (sel < NSRC) return src[sel];
    return '0;
  endfunction

  // Inputs change 1 time unit after posedge, so negedge sees pre-edge values.
  always @(negedge CLK) begin
    if (hold_pend && out_valid) chk("hold", srcB, hold_val);
    if (!RST_N || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_out", srcB, 32'hDEAD_BEEF ^ srcB);
        else chk("sb_data", srcB, sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back(model(int'(alu_srcB)));
    end
    hold_pend = RST_N && !flush && out_valid && !out_ready;
    hold_val  = srcB;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [SELW-1:0] sel);
    in_valid = 1'b1;
    alu_srcB = sel;
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; in_valid = 1'b0; alu_srcB = '0; flush = 1'b0; out_ready = 1'b0;
    fwd_mem_valid = 1'b0; fwd_wb_valid = 1'b0; fwd_mem_data = '0; fwd_wb_data = '0;
    for (int k = 0; k < NSRC; k++) src[k] = 32'h100 * k + 32'h7;
    @(negedge CLK);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    @(negedge CLK);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_srcB", srcB, 32'd0);
    chk("rst_sel_err", {31'b0, sel_err}, 32'd0);
    tick();
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic select, back-to-back
    out_ready = 1'b1;
    src[1] = 32'h0000_0ABC; src[3] = 32'h0000_1000;
    tick();
    send(3'd1);
    alu_srcB = 3'd3;
    @(negedge CLK);
    chk("lat_out_valid", {31'b0, out_valid}, 32'd1);
    chk("basic_first", srcB, 32'h0000_0ABC);
    tick();
    in_valid = 1'b0;
    @(negedge CLK);
    chk("basic_out_valid", {31'b0, out_valid}, 32'd1);
    chk("basic_second", srcB, 32'h0000_1000);
    idle(2);

    // Forwarding priority
    src[0] = 32'h1111_1111; src[2] = 32'h5A5A_5A5A;
    fwd_wb_valid = 1'b1; fwd_wb_data = 32'h2222_2222;
    fwd_mem_valid = 1'b1; fwd_mem_data = 32'h3333_3333;
    send(3'd0);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("fwd_mem", srcB, 32'h3333_3333);
    fwd_mem_valid = 1'b0;
    send(3'd0);
    fwd_wb_valid = 1'b0;
    send(3'd0);
    fwd_mem_valid = 1'b1; fwd_wb_valid = 1'b1;
    send(3'd2);
    in_valid = 1'b0;
    fwd_mem_valid = 1'b0; fwd_wb_valid = 1'b0;
    @(negedge CLK);
    chk("fwd_ignored_sel2", srcB, 32'h5A5A_5A5A);
    idle(2);

    // Skid under backpressure
    out_ready = 1'b0;
    src[1] = 32'hA; send(3'd1);
    src[1] = 32'hB; send(3'd1);
    src[1] = 32'hC; in_valid = 1'b1; alu_srcB = 3'd1;
    @(negedge CLK);
    chk("skid_in_ready", {31'b0, in_ready}, 32'd0);
    chk("skid_head", srcB, 32'hA);
    tick();
    src[1] = 32'hFFFF_0000;
    @(negedge CLK);
    chk("skid_held", srcB, 32'hA);
    src[1] = 32'hC;
    out_ready = 1'b1;
    tick();
    tick();
    idle(3);
    chk("skid_drained", sb.size(), 32'd0);

    // Illegal select
    send(3'd6);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("ill_srcB", srcB, 32'd0);
    chk("ill_sel_err", {31'b0, sel_err}, 32'd1);
    src[4] = 32'hCAFE_0004;
    send(3'd4);
    send(3'd7);
    send(3'd5);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("ill_sticky", {31'b0, sel_err}, 32'd1);
    idle(2);

    // Flush with OUT and SKID full
    out_ready = 1'b0;
    src[1] = 32'h1; send(3'd1);
    src[1] = 32'h2; send(3'd1);
    src[1] = 32'hD; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge CLK);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    idle(3);

    // Flush together with a real accept
    out_ready = 1'b0;
    src[1] = 32'h3; send(3'd1);
    src[1] = 32'h4; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge CLK);
    chk("flush_acc_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_acc_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    idle(3);

    // Reset mid-stream
    src[5] = 32'h5555_AAAA;
    send(3'd5);
    in_valid = 1'b0;
    RST_N = 1'b0;
    @(negedge CLK);
    chk("midrst_pre_out_valid", {31'b0, out_valid}, 32'd1);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    @(negedge CLK);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_srcB", srcB, 32'd0);
    chk("midrst_sel_err", {31'b0, sel_err}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("midrst_in_ready_after", {31'b0, in_ready}, 32'd1);
    src[3] = 32'h0000_3333;
    send(3'd3);
    idle(3);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
